// File: rtl/score_tick_timer.sv
// Whack-a-mole game timer: synchronizes the slow score clock into single-cycle ticks,
// counts game seconds down in BCD and keeps a saturating BCD score.
module score_tick_timer #(
  parameter int GAME_SECONDS  = 60,
  parameter int TICKS_PER_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic       tick,
  output logic [7:0] time_bcd,
  output logic [7:0] score_bcd,
  output logic       running,
  output logic       game_over
);

  localparam logic [7:0] TIME_INIT  = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t     state, state_n;
  logic [7:0] time_n, score_n;
  logic [7:0] presc, presc_n;
  logic       sync1, sync2, sync3, edge_det, rst_hold;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)        return v;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)        return v;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // rst_hold masks start for the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      edge_det <= 1'b0;
      tick     <= 1'b0;
      rst_hold <= 1'b1;
    end else begin
      sync1    <= slow_clk;
      sync2    <= sync1;
      sync3    <= sync2;
      edge_det <= sync2 & ~sync3;
      tick     <= edge_det;
      rst_hold <= 1'b0;
    end
  end

  // The FSM consumes edge_det so time changes on the same edge that raises tick.
  always_comb begin
    state_n = state;
    time_n  = time_bcd;
    score_n = score_bcd;
    presc_n = presc;
    case (state)
      IDLE: begin
        time_n  = TIME_INIT;
        score_n = 8'h00;
        presc_n = 8'd0;
        if (start && !rst_hold) state_n = RUN;
      end
      RUN: begin
        if (hit && !miss)      score_n = bcd_inc(score_bcd);
        else if (miss && !hit) score_n = bcd_dec(score_bcd);
        if (edge_det) begin
          if (presc == PRESC_LAST) begin
            presc_n = 8'd0;
            time_n  = bcd_dec(time_bcd);
            if (time_bcd == 8'h01) state_n = OVER;
          end else begin
            presc_n = presc + 8'd1;
          end
        end
      end
      OVER: begin
        time_n = 8'h00;
        if (start && !rst_hold) begin
          state_n = RUN;
          time_n  = TIME_INIT;
          score_n = 8'h00;
          presc_n = 8'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      time_bcd  <= TIME_INIT;
      score_bcd <= 8'h00;
      presc     <= 8'd0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      time_bcd  <= time_n;
      score_bcd <= score_n;
      presc     <= presc_n;
      running   <= (state_n == RUN);
      game_over <= (state_n == OVER);
    end
  end

endmodule

// File: tb/tb_score_tick_timer.sv
// Directed bench for score_tick_timer: a 3-second game instance and a 99-second instance
// for saturation, with expectations queued at drive time and popped at compare time.
module tb_score_tick_timer;

  logic clk = 1'b0, reset = 1'b0, slow_clk = 1'b0;
  logic start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic start2 = 1'b0, hit2 = 1'b0, miss2 = 1'b0;
  logic tick, running, game_over, tick2, running2, over2;
  logic [7:0] time_bcd, score_bcd, time2, score2;

  score_tick_timer #(.GAME_SECONDS(3), .TICKS_PER_SEC(2)) dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .hit(hit), .miss(miss),
    .tick(tick), .time_bcd(time_bcd), .score_bcd(score_bcd), .running(running), .game_over(game_over));

  score_tick_timer #(.GAME_SECONDS(99), .TICKS_PER_SEC(2)) dut2 (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .start(start2), .hit(hit2), .miss(miss2),
    .tick(tick2), .time_bcd(time2), .score_bcd(score2), .running(running2), .game_over(over2));

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_score;
  int   model_score2;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) + (n % 10));
  endfunction

  task automatic push(input string tag, input logic [7:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t it;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rise_half();
    slow_clk = 1'b1;
    repeat (4) step();
  endtask

  task automatic fall_half();
    slow_clk = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    // Reset values without any clock edge being required
    #2 reset = 1'b1;
    #2;
    push("rst_time", 8'h03);   chk(time_bcd);
    push("rst_score", 8'h00);  chk(score_bcd);
    push("rst_running", 8'h0); chk({7'b0, running});
    push("rst_over", 8'h0);    chk({7'b0, game_over});
    push("rst_tick", 8'h0);    chk({7'b0, tick});
    push("rst_time2", 8'h99);  chk(time2);

    // Start coincident with reset release must be ignored
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    push("start_at_release", 8'h0); chk({7'b0, running});

    // Tick timing in IDLE: one pulse 3 edges after the first high sample
    slow_clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push("tick_rise", (i == 3) ? 8'h1 : 8'h0);
      step();
      chk({7'b0, tick});
    end
    slow_clk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push("tick_fall", 8'h0);
      step();
      chk({7'b0, tick});
    end
    push("idle_time", 8'h03); chk(time_bcd);

    start = 1'b1;
    step();
    start = 1'b0;
    push("run_entry", 8'h1);   chk({7'b0, running});
    push("run_time", 8'h03);   chk(time_bcd);
    push("run_score", 8'h00);  chk(score_bcd);

    // Score arithmetic
    model_score = 0;
    hit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      model_score = (model_score < 99) ? model_score + 1 : 99;
      push("hit_inc", to_bcd(model_score));
      step();
      chk(score_bcd);
    end
    hit  = 1'b0;
    miss = 1'b1;
    for (int i = 0; i < 11; i++) begin
      model_score = (model_score > 0) ? model_score - 1 : 0;
      push("miss_dec", to_bcd(model_score));
      step();
      chk(score_bcd);
    end
    miss = 1'b0;
    hit  = 1'b1;
    model_score = model_score + 1;
    push("hit_after_zero", to_bcd(model_score));
    step();
    chk(score_bcd);
    miss = 1'b1;
    push("hit_and_miss", to_bcd(model_score));
    step();
    chk(score_bcd);
    hit   = 1'b0;
    miss  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    push("start_in_run_time", 8'h03); chk(time_bcd);
    push("start_in_run_run", 8'h1);   chk({7'b0, running});

    // Full game: second decrements every 2 ticks
    for (int k = 1; k <= 5; k++) begin
      rise_half();
      push("game_tick", 8'h1);            chk({7'b0, tick});
      push("game_time", to_bcd(3 - k / 2)); chk(time_bcd);
      push("game_running", 8'h1);         chk({7'b0, running});
      fall_half();
    end

    // Hit coincident with the final tick is counted before OVER
    slow_clk = 1'b1;
    repeat (3) step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    model_score = model_score + 1;
    push("final_tick", 8'h1);           chk({7'b0, tick});
    push("final_score", to_bcd(model_score)); chk(score_bcd);
    push("final_time", 8'h00);          chk(time_bcd);
    push("final_over", 8'h1);           chk({7'b0, game_over});
    push("final_running", 8'h0);        chk({7'b0, running});
    fall_half();

    hit = 1'b1;
    step();
    hit  = 1'b0;
    miss = 1'b1;
    step();
    miss = 1'b0;
    push("over_score_hold", to_bcd(model_score)); chk(score_bcd);
    rise_half();
    fall_half();
    push("over_time_hold", 8'h00); chk(time_bcd);
    push("over_state", 8'h1);      chk({7'b0, game_over});

    // Restart from OVER
    start = 1'b1;
    step();
    start = 1'b0;
    push("restart_run", 8'h1);    chk({7'b0, running});
    push("restart_over", 8'h0);   chk({7'b0, game_over});
    push("restart_score", 8'h00); chk(score_bcd);
    push("restart_time", 8'h03);  chk(time_bcd);

    // Reset mid-game, with a tick already in the pipeline
    rise_half(); fall_half(); rise_half(); fall_half();
    push("pre_reset_time", 8'h02); chk(time_bcd);
    hit = 1'b1;
    step();
    hit = 1'b0;
    push("pre_reset_score", 8'h01); chk(score_bcd);
    slow_clk = 1'b1;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    push("midrst_time", 8'h03);   chk(time_bcd);
    push("midrst_score", 8'h00);  chk(score_bcd);
    push("midrst_running", 8'h0); chk({7'b0, running});
    slow_clk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push("post_rst_no_tick", 8'h0);
      step();
      chk({7'b0, tick});
    end
    rise_half();
    push("post_rst_fresh_tick", 8'h1); chk({7'b0, tick});
    push("post_rst_idle", 8'h0);       chk({7'b0, running});
    fall_half();

    // Saturation on the 99-second instance
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    push("sat_running", 8'h1); chk({7'b0, running2});
    model_score2 = 0;
    hit2 = 1'b1;
    for (int i = 0; i < 105; i++) begin
      model_score2 = (model_score2 < 99) ? model_score2 + 1 : 99;
      push("sat_hit", to_bcd(model_score2));
      step();
      chk(score2);
    end
    hit2 = 1'b0;
    for (int i = 0; i < 178; i++) begin
      rise_half();
      fall_half();
    end
    push("sat_time_10", 8'h10); chk(time2);
    rise_half(); fall_half();
    push("sat_time_half", 8'h10); chk(time2);
    rise_half(); fall_half();
    push("sat_time_09", 8'h09); chk(time2);
    push("sat_score_hold", 8'h99); chk(score2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
